// File: rtl/npu_pkg.sv
// Types and default sizes shared by the NPU matrix-multiply datapath.
package npu_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int NPU_BIT_WIDTH = 8;
  localparam int NPU_ACC_WIDTH = 32;
  localparam int NPU_MAX_LEN   = 256;

endpackage

// File: rtl/sat_add_u.sv
// Combinational unsigned saturating adder. The extra carry bit decides
// whether the result clips to all-ones.
module sat_add_u #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 16
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [A_WIDTH-1:0] sum,
  output logic               overflow
);

  logic [A_WIDTH:0] raw;

  assign raw      = {1'b0, a} + {{(A_WIDTH + 1 - B_WIDTH){1'b0}}, b};
  assign overflow = raw[A_WIDTH];
  assign sum      = overflow ? '1 : raw[A_WIDTH-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// Reduction stage after the product multiplier: sums one dot-product vector
// per result beat with unsigned saturation and a forced cut at MAX_LEN.
//
// state | meaning
// ACCUM | no result pending, accepting product beats
// HOLD  | result registers valid and stable until the consumer takes them
module mac_accumulator
  import npu_pkg::*;
#(
  parameter int BIT_WIDTH  = NPU_BIT_WIDTH,
  parameter int PROD_WIDTH = 2 * BIT_WIDTH,
  parameter int ACC_WIDTH  = NPU_ACC_WIDTH,
  parameter int MAX_LEN    = NPU_MAX_LEN,
  parameter int CNT_W      = $clog2(MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_product,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_sat,
  output logic                  out_forced
);

  acc_state_e           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] add_a;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 sat;
  logic                 sat_next;
  logic                 first;
  logic                 accept;
  logic                 at_max;
  logic                 vec_end;

  assign in_ready  = !clear && ((state == ACCUM) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  // The accumulator is emptied whenever a vector ends, so an empty count
  // marks the first beat and the stale sum is never added in.
  assign first    = (cnt == '0);
  assign add_a    = first ? '0 : acc;
  assign sat_next = add_ovf || (!first && sat);
  assign cnt_next = first ? CNT_W'(1) : cnt + CNT_W'(1);
  assign at_max   = (cnt_next == CNT_W'(MAX_LEN));
  assign vec_end  = in_last || at_max;

  sat_add_u #(
    .A_WIDTH (ACC_WIDTH),
    .B_WIDTH (PROD_WIDTH)
  ) u_sat_add (
    .a        (add_a),
    .b        (in_product),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_sat    <= 1'b0;
      out_forced <= 1'b0;
    end else if (clear) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else if (accept) begin
      if (vec_end) begin
        state      <= HOLD;
        out_sum    <= add_sum;
        out_count  <= cnt_next;
        out_sat    <= sat_next;
        out_forced <= at_max && !in_last;
        acc        <= '0;
        cnt        <= '0;
        sat        <= 1'b0;
      end else begin
        // A beat taken in HOLD also consumes the pending result.
        state <= ACCUM;
        acc   <= add_sum;
        cnt   <= cnt_next;
        sat   <= sat_next;
      end
    end else if ((state == HOLD) && out_ready) begin
      state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios on three
// parameterisations plus a randomized stream against a vector-level model.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // default configuration
  logic        m_clear, m_in_valid, m_in_ready, m_in_last;
  logic [15:0] m_in_product;
  logic        m_out_valid, m_out_ready, m_out_sat, m_out_forced;
  logic [31:0] m_out_sum;
  logic [8:0]  m_out_count;

  // 16-bit accumulator
  logic        s_clear, s_in_valid, s_in_ready, s_in_last;
  logic [15:0] s_in_product;
  logic        s_out_valid, s_out_ready, s_out_sat, s_out_forced;
  logic [15:0] s_out_sum;
  logic [8:0]  s_out_count;

  // MAX_LEN = 4
  logic        f_clear, f_in_valid, f_in_ready, f_in_last;
  logic [15:0] f_in_product;
  logic        f_out_valid, f_out_ready, f_out_sat, f_out_forced;
  logic [31:0] f_out_sum;
  logic [2:0]  f_out_count;

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(m_clear),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_product(m_in_product), .in_last(m_in_last),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_sum(m_out_sum),
    .out_count(m_out_count), .out_sat(m_out_sat), .out_forced(m_out_forced)
  );

  mac_accumulator #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(s_clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_product(s_in_product), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_count(s_out_count), .out_sat(s_out_sat), .out_forced(s_out_forced)
  );

  mac_accumulator #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(f_clear),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_product(f_in_product), .in_last(f_in_last),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_sum(f_out_sum),
    .out_count(f_out_count), .out_sat(f_out_sat), .out_forced(f_out_forced)
  );

  typedef struct {
    longint sum;
    int     cnt;
    bit     sat;
    bit     forced;
  } result_t;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
  localparam int     MAXL = 256;

  result_t exp_q[$];
  longint  cur_sum = 0;
  int      cur_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    m_clear = 0; m_in_valid = 0; m_in_last = 0; m_in_product = '0; m_out_ready = 0;
    s_clear = 0; s_in_valid = 0; s_in_last = 0; s_in_product = '0; s_out_ready = 0;
    f_clear = 0; f_in_valid = 0; f_in_last = 0; f_in_product = '0; f_out_ready = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({m_out_valid, m_out_sum, m_out_count, m_out_sat, m_out_forced} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b sum=%0d count=%0d sat=%0b forced=%0b, all must be 0",
               m_out_valid, m_out_sum, m_out_count, m_out_sat, m_out_forced);
    end
    rst_n = 1;
    tick;
    vectors++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", m_in_ready);
    end
    vectors++;
    if (s_out_valid !== 1'b0 || f_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_aux_valid: got %0b/%0b expected 0/0", s_out_valid, f_out_valid);
    end
  endtask

  task automatic test_basic;
    m_out_ready = 1; m_in_valid = 1; m_in_last = 0;
    m_in_product = 16'd50;    tick;
    m_in_product = 16'd0;     tick;
    m_in_product = 16'd65025; tick;
    vectors++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %0b expected 0", m_out_valid);
    end
    m_in_product = 16'd5535; m_in_last = 1; tick;
    m_in_valid = 0; m_in_last = 0;
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_sum !== 32'd70610 || m_out_count !== 9'd4) begin
      errors++;
      $display("FAIL basic_result: valid=%0b sum=%0d count=%0d expected 1/70610/4",
               m_out_valid, m_out_sum, m_out_count);
    end
    vectors++;
    if (m_out_sat !== 1'b0 || m_out_forced !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: sat=%0b forced=%0b expected 0/0", m_out_sat, m_out_forced);
    end
    tick;
    vectors++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_consumed: valid=%0b expected 0", m_out_valid);
    end
  endtask

  task automatic test_backpressure;
    m_out_ready = 1; m_in_valid = 1; m_in_last = 0;
    m_in_product = 16'd1; tick;
    m_in_product = 16'd2; m_in_last = 1; tick;
    m_out_ready = 0; m_in_product = 16'd7; m_in_last = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (m_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, m_in_ready);
      end
      vectors++;
      if (m_out_valid !== 1'b1 || m_out_sum !== 32'd3 || m_out_count !== 9'd2) begin
        errors++;
        $display("FAIL stall_payload[%0d]: valid=%0b sum=%0d count=%0d expected 1/3/2",
                 i, m_out_valid, m_out_sum, m_out_count);
      end
      tick;
    end
    m_out_ready = 1;
    #1;
    vectors++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %0b expected 1", m_in_ready);
    end
    tick;
    m_in_valid = 0; m_in_last = 0;
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_sum !== 32'd7 || m_out_count !== 9'd1) begin
      errors++;
      $display("FAIL no_bubble_result: valid=%0b sum=%0d count=%0d expected 1/7/1",
               m_out_valid, m_out_sum, m_out_count);
    end
    tick;
  endtask

  task automatic test_clear;
    m_out_ready = 1; m_in_valid = 1; m_in_last = 0;
    m_in_product = 16'd3; tick;
    m_in_product = 16'd4; tick;
    m_clear = 1; m_in_product = 16'd50;
    #1;
    vectors++;
    if (m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_ready: got %0b expected 0", m_in_ready);
    end
    tick;
    m_clear = 0; m_in_product = 16'd9; m_in_last = 1;
    tick;
    m_in_valid = 0; m_in_last = 0; m_out_ready = 0;
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_sum !== 32'd9 || m_out_count !== 9'd1) begin
      errors++;
      $display("FAIL clear_restart: valid=%0b sum=%0d count=%0d expected 1/9/1",
               m_out_valid, m_out_sum, m_out_count);
    end
    tick;
    m_clear = 1;
    tick;
    m_clear = 0;
    vectors++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold: valid=%0b expected 0", m_out_valid);
    end
    m_out_ready = 1;
    tick;
  endtask

  task automatic rand_cycle(input logic iv, input logic [15:0] p, input logic lst, input logic ordy);
    logic    exp_rdy;
    logic    exp_vld;
    result_t r;
    m_in_valid = iv; m_in_product = p; m_in_last = lst; m_out_ready = ordy; m_clear = 0;
    #1;
    exp_vld = (exp_q.size() != 0);
    exp_rdy = !exp_vld || ordy;
    vectors++;
    if (m_in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL rand_in_ready: got %0b expected %0b at %0t", m_in_ready, exp_rdy, $time);
    end
    vectors++;
    if (m_out_valid !== exp_vld) begin
      errors++;
      $display("FAIL rand_out_valid: got %0b expected %0b at %0t", m_out_valid, exp_vld, $time);
    end
    if (exp_vld && ordy) begin
      r = exp_q.pop_front();
      vectors++;
      if (m_out_sum !== r.sum[31:0] || m_out_count !== r.cnt[8:0] ||
          m_out_sat !== r.sat || m_out_forced !== r.forced) begin
        errors++;
        $display("FAIL rand_result: got sum=%0d count=%0d sat=%0b forced=%0b expected %0d/%0d/%0b/%0b",
                 m_out_sum, m_out_count, m_out_sat, m_out_forced, r.sum, r.cnt, r.sat, r.forced);
      end
    end
    if (iv && exp_rdy) begin
      cur_sum += longint'(p);
      cur_cnt++;
      if (lst || cur_cnt == MAXL) begin
        r.sat    = (cur_sum > MAXV);
        r.sum    = r.sat ? MAXV : cur_sum;
        r.cnt    = cur_cnt;
        r.forced = !lst;
        exp_q.push_back(r);
        cur_sum = 0;
        cur_cnt = 0;
      end
    end
    tick;
  endtask

  task automatic test_random;
    logic [15:0] p;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 16'd0;
        1:       p = 16'hFFFF;
        default: p = 16'($urandom_range(0, 65535));
      endcase
      rand_cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 4 && cur_cnt != 0; k++) rand_cycle(1'b1, 16'd1, 1'b1, 1'b1);
    rand_cycle(1'b0, 16'd0, 1'b0, 1'b1);
    rand_cycle(1'b0, 16'd0, 1'b0, 1'b1);
    vectors++;
    if (exp_q.size() != 0 || cur_cnt != 0 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: pending=%0d partial=%0d valid=%0b expected 0/0/0",
               exp_q.size(), cur_cnt, m_out_valid);
    end
  endtask

  task automatic test_saturation;
    s_out_ready = 1; s_in_valid = 1; s_in_last = 0;
    s_in_product = 16'd65025; tick;
    s_in_last = 1; tick;
    vectors++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 16'd65535 || s_out_sat !== 1'b1 || s_out_count !== 9'd2) begin
      errors++;
      $display("FAIL sat_result: valid=%0b sum=%0d sat=%0b count=%0d expected 1/65535/1/2",
               s_out_valid, s_out_sum, s_out_sat, s_out_count);
    end
    s_in_product = 16'd10; tick;
    s_in_valid = 0; s_in_last = 0;
    vectors++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 16'd10 || s_out_sat !== 1'b0 || s_out_count !== 9'd1) begin
      errors++;
      $display("FAIL sat_next_vector: valid=%0b sum=%0d sat=%0b count=%0d expected 1/10/0/1",
               s_out_valid, s_out_sum, s_out_sat, s_out_count);
    end
    tick;
  endtask

  task automatic test_forced;
    f_out_ready = 1; f_in_valid = 1; f_in_last = 0; f_in_product = 16'd1;
    repeat (3) tick;
    vectors++;
    if (f_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL forced_early: valid=%0b expected 0", f_out_valid);
    end
    tick;
    vectors++;
    if (f_out_valid !== 1'b1 || f_out_sum !== 32'd4 || f_out_count !== 3'd4 || f_out_forced !== 1'b1) begin
      errors++;
      $display("FAIL forced_result: valid=%0b sum=%0d count=%0d forced=%0b expected 1/4/4/1",
               f_out_valid, f_out_sum, f_out_count, f_out_forced);
    end
    tick;
    vectors++;
    if (f_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL forced_fifth: valid=%0b expected 0", f_out_valid);
    end
    f_in_last = 1; tick;
    vectors++;
    if (f_out_sum !== 32'd2 || f_out_count !== 3'd2 || f_out_forced !== 1'b0) begin
      errors++;
      $display("FAIL forced_carry: sum=%0d count=%0d forced=%0b expected 2/2/0",
               f_out_sum, f_out_count, f_out_forced);
    end
    f_in_last = 0; repeat (3) tick;
    f_in_last = 1; tick;
    f_in_valid = 0; f_in_last = 0;
    vectors++;
    if (f_out_valid !== 1'b1 || f_out_count !== 3'd4 || f_out_forced !== 1'b0) begin
      errors++;
      $display("FAIL last_at_max: valid=%0b count=%0d forced=%0b expected 1/4/0",
               f_out_valid, f_out_count, f_out_forced);
    end
    tick;
  endtask

  task automatic test_async_reset;
    m_out_ready = 1; m_in_valid = 1; m_in_last = 1; m_in_product = 16'd6; tick;
    m_in_last = 0; m_in_product = 16'd100; tick;
    m_in_valid = 0;
    vectors++;
    if (m_out_sum !== 32'd6) begin
      errors++;
      $display("FAIL prereset_sum: got %0d expected 6", m_out_sum);
    end
    #3 rst_n = 0;
    #1;
    vectors++;
    if ({m_out_valid, m_out_sum, m_out_count, m_out_sat, m_out_forced} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b sum=%0d count=%0d, all must be 0",
               m_out_valid, m_out_sum, m_out_count);
    end
    #2 rst_n = 1;
    tick;
    m_in_valid = 1; m_in_product = 16'd2; tick;
    m_in_product = 16'd3; m_in_last = 1; tick;
    m_in_valid = 0; m_in_last = 0;
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_sum !== 32'd5 || m_out_count !== 9'd2) begin
      errors++;
      $display("FAIL post_reset: valid=%0b sum=%0d count=%0d expected 1/5/2",
               m_out_valid, m_out_sum, m_out_count);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_clear;
    test_random;
    test_saturation;
    test_forced;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream stage of the registered `dsp_mult` multiplier. It consumes the product stream with a valid/ready handshake and accumulates one dot-product vector at a time into a wide unsigned sum. For each vector it emits one result beat carrying the sum, the beat count and status flags. It is the reduction stage of the NPU's matrix-multiply datapath.

## Interface
- `BIT_WIDTH`, 8: multiplier operand width.
- `PROD_WIDTH`, 2*BIT_WIDTH: width of the incoming product.
- `ACC_WIDTH`, 32: accumulator and result width; must be ≥ PROD_WIDTH.
- `MAX_LEN`, 256: maximum beats per vector; must be ≥ 2.
- `CNT_W`, $clog2(MAX_LEN)+1: derived count width; not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous abort of the partial vector and any pending result.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  accumulator can take a beat.
- `in_product`  in  PROD_WIDTH  unsigned product from the multiplier.
- `in_last`  in  1  marks the final beat of the vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_WIDTH  accumulated sum.
- `out_count`  out  CNT_W  number of beats in the vector, 1..MAX_LEN.
- `out_sat`  out  1  the sum saturated during this vector.
- `out_forced`  out  1  the vector was terminated at MAX_LEN without `in_last`.

## Operation
- States:
  - ACCUM: `out_valid`=0, accepting beats.
  - HOLD: `out_valid`=1, result registers stable until accepted.
- Beats are accepted when `in_valid && in_ready`.
- `in_ready = !clear && (state==ACCUM || out_ready)`. In HOLD, a beat is accepted only in the cycle the result is consumed.
- Accepted beat:
  - Add `in_product` (zero-extended) to `acc` with unsigned saturation at 2^ACC_WIDTH-1. Any clipped add sets sticky `sat`.
  - `cnt` increments.
- The first beat of a vector loads `acc = in_product` rather than adding to the stale value. `sat` and `cnt` restart in the same way.
- End of vector occurs on an accepted beat with `in_last=1`, or on the beat that brings `cnt` to MAX_LEN. In the second case `forced=1`; it is 0 if `in_last` is also set on that beat.
- At end of vector, the final sum, count and flags are latched into the output registers and the state moves to HOLD.
- In HOLD with `out_ready=1`, the result is consumed:
  - With no simultaneous beat, the state returns to ACCUM with an empty accumulator.
  - With a simultaneous beat, that beat is the first beat of the next vector, and that vector is accumulated from it. If the beat is also last (a single-beat vector), the state stays HOLD with the new result.
- `clear=1`: the next state is ACCUM, the accumulator is empty, `out_valid`=0 and any pending result is discarded. `clear` has priority over all other events; `in_ready` is 0 during clear.
- Arithmetic is unsigned only. Add width is ACC_WIDTH+1 internally, and the carry selects saturation.

## Timing
- Reset values:
  - state = ACCUM
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0, `out_forced`=0
  - internal `acc`, `cnt`, `sat` = 0
- `in_ready` is combinational from state, `out_ready` and `clear`. All other outputs are registered.
- Latency: `out_valid` rises on the clock edge that accepts the ending beat, so the result is visible the cycle after the last handshake.
- Throughput: one beat per cycle sustained. Back-to-back vectors, including single-beat vectors, incur no bubble when `out_ready=1`.
- `out_*` payload is held constant while `out_valid && !out_ready`.
- `rst_n` low mid-vector or in HOLD: all state returns to reset values immediately (asynchronously). The partial sum is lost.

## Structure
- Shared package `npu_pkg`:
  - `acc_state_e` enum {ACCUM, HOLD}
  - default constants `NPU_BIT_WIDTH`=8, `NPU_ACC_WIDTH`=32, `NPU_MAX_LEN`=256
- Sub-module `sat_add_u`: parameterised unsigned saturating adder with outputs sum and overflow. It is combinational and instanced once.
- Top level contains the FSM, the beat counter, the accumulator and the output register bank.

## Test plan
- Stream 50, 0, 65025, 5535 with last on beat 4, `out_ready`=1 → `out_sum`=70610, `out_count`=4, `out_sat`=0, `out_valid` one cycle after beat 4.
- ACC_WIDTH=16, beats 65025, 65025 (last) → `out_sum`=65535, `out_sat`=1. The next vector, single beat 10 → `out_sum`=10, `out_sat`=0.
- MAX_LEN=4, five beats of 1 with no last → result `out_sum`=4, `out_count`=4, `out_forced`=1. The fifth beat starts a new vector.
- `out_ready`=0 for 5 cycles after a result → `in_ready`=0 and payload stable. Then drive `out_ready`=1 with a beat of 7 (last) in the same cycle → the next result is 7, with no bubble.
- Assert `clear` mid-vector after beats 3 and 4, then send beat 9 (last) → `out_sum`=9, `out_count`=1. `clear` in HOLD → `out_valid` drops the next cycle.
- Drop `rst_n` asynchronously mid-vector → all outputs 0 immediately. After release, beats 2, 3 (last) → `out_sum`=5.
